// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions for the MEM-stage load/store unit.
// Holds the RV32I load/store funct3 codes and the LSU state encoding.
package cpu_defs;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // IDLE must stay at zero: reset clears the state register to all zeros.
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
//   st_size/st_lane/st_wdata -> st_be, st_wdata_lane : store byte enables and
//                                                      lane-replicated data
//   ld_funct3/ld_lane/ld_rdata -> ld_data            : load extract with
//                                                      sign/zero extension
// st_size is funct3[1:0] (00 byte, 01 half, 1x word).
module lsu_align
  import cpu_defs::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_lane,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_be         = '0;
    st_wdata_lane = '0;
    case (st_size)
      2'b00: begin
        st_be         = 4'b0001 << st_lane;
        st_wdata_lane = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        st_be         = st_lane[1] ? 4'b1100 : 4'b0011;
        st_wdata_lane = {2{st_wdata[15:0]}};
      end
      default: begin
        st_be         = '1;
        st_wdata_lane = st_wdata;
      end
    endcase
  end

  // funct3[2] set means unsigned (lbu/lhu): extension bit forced to zero.
  always_comb begin
    shifted = ld_rdata >> {ld_lane, 3'b000};
    ld_data = ld_rdata;
    case (ld_funct3[1:0])
      2'b00:   ld_data = {{24{shifted[7]  & ~ld_funct3[2]}}, shifted[7:0]};
      2'b01:   ld_data = {{16{shifted[15] & ~ld_funct3[2]}}, shifted[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// MEM-stage load/store unit: turns an EX/MEM load/store into a registered
// req/ack data-memory transaction, stalling the pipeline while it is open.
//   op_valid/mem_read/mem_write/funct3/addr/wdata/flush : pipeline op inputs
//   stall, addr_fault                                   : combinational status
//   load_data/load_valid/bus_err                        : results to writeback
//   dmem_req/we/addr/be/wdata, dmem_ack/rdata           : memory bus
// TIMEOUT (>=2) is the number of unacknowledged REQ cycles before bus_err;
// CNT_W must be wide enough to hold TIMEOUT.
module lsu_dmem_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_fault,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        f3_q, f3_d;
  logic              flushed_q, flushed_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d, bus_err_q, bus_err_d;

  logic              access, f3_ok, is_half, is_word, start;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata_lane, ld_data;

  lsu_align u_align (
    .st_size       (funct3[1:0]),
    .st_lane       (addr[1:0]),
    .st_wdata      (wdata),
    .st_be         (st_be),
    .st_wdata_lane (st_wdata_lane),
    .ld_funct3     (f3_q),
    .ld_lane       (lane_q),
    .ld_rdata      (dmem_rdata),
    .ld_data       (ld_data)
  );

  always_comb begin
    access  = op_valid & (mem_read | mem_write);
    is_half = (funct3[1:0] == 2'b01);
    is_word = (funct3[1:0] == 2'b10);
    // Store encodings coincide with lb/lh/lw; only the unsigned codes are load-only.
    case (funct3)
      FUNCT3_LB, FUNCT3_LH, FUNCT3_LW: f3_ok = 1'b1;
      FUNCT3_LBU, FUNCT3_LHU:          f3_ok = mem_read;
      default:                         f3_ok = 1'b0;
    endcase
    addr_fault = access & (~f3_ok | (is_half & addr[0]) | (is_word & (|addr[1:0])));
    start      = access & ~addr_fault & ~flush & (state_q == LSU_IDLE);
    stall      = start | (state_q == LSU_REQ);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    lane_d       = lane_q;
    f3_d         = f3_q;
    flushed_d    = flushed_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (start) begin
          state_d   = LSU_REQ;
          req_d     = 1'b1;
          we_d      = mem_write;
          addr_d    = {addr[31:2], 2'b00};
          be_d      = st_be;
          wdata_d   = st_wdata_lane;
          lane_d    = addr[1:0];
          f3_d      = funct3;
          flushed_d = 1'b0;
          cnt_d     = '0;
        end
      end
      LSU_REQ: begin
        // A flush never abandons the bus; it only suppresses the load result.
        if (flush) flushed_d = 1'b1;
        if (dmem_ack) begin
          state_d = LSU_DONE;
          req_d   = 1'b0;
          cnt_d   = '0;
          if (!we_q && !(flushed_q || flush)) begin
            load_data_d  = ld_data;
            load_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = LSU_DONE;
          req_d     = 1'b0;
          cnt_d     = '0;
          bus_err_d = 1'b1;
          if (!we_q) load_data_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      lane_q       <= '0;
      f3_q         <= '0;
      flushed_q    <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      lane_q       <= lane_d;
      f3_q         <= f3_d;
      flushed_q    <= flushed_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign bus_err    = bus_err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl. Expected load results are queued when
// a load is issued and compared by a monitor whenever load_valid pulses.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, load_valid, addr_fault, bus_err, dmem_req, dmem_we;
  logic [31:0] load_data, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .flush(flush), .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .addr_fault(addr_fault), .bus_err(bus_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  // Scoreboard monitor: every load_valid pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n && load_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: load_valid with load_data=%h, no load expected", load_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (load_data !== sb_exp) begin
          errors++;
          $display("FAIL sb_load_data: got %h expected %h", load_data, sb_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    op_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
  endtask

  task automatic clear_op();
    op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({stall, load_valid, bus_err, dmem_req, dmem_we, dmem_be} !== 9'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {stall, load_valid, bus_err, dmem_req, dmem_we, dmem_be});
    end
    checks++;
    if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data: got %h expected 0", load_data); end
    checks++;
    if (dmem_addr !== 32'h0) begin errors++; $display("FAIL reset_dmem_addr: got %h expected 0", dmem_addr); end
    checks++;
    if (dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_dmem_wdata: got %h expected 0", dmem_wdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_lb();
    @(posedge clk) #1; set_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, '0);
    exp_q.push_back(32'hFFFF_FF80);
    @(negedge clk);
    checks++;
    if ({stall, dmem_req} !== 2'b10) begin errors++; $display("FAIL lb_cycleN: stall,req=%b expected 10", {stall, dmem_req}); end
    @(posedge clk) #1; dmem_ack = 1'b1; dmem_rdata = 32'h80FF_1234;
    @(negedge clk);
    checks++;
    if ({stall, dmem_req, dmem_we} !== 3'b110) begin errors++; $display("FAIL lb_req: stall,req,we=%b expected 110", {stall, dmem_req, dmem_we}); end
    checks++;
    if (dmem_addr !== 32'h0000_0100) begin errors++; $display("FAIL lb_addr: got %h expected 00000100", dmem_addr); end
    @(posedge clk) #1; dmem_ack = 1'b0; dmem_rdata = '0;
    @(negedge clk);
    checks++;
    if ({stall, dmem_req, load_valid} !== 3'b001) begin errors++; $display("FAIL lb_done: stall,req,lv=%b expected 001", {stall, dmem_req, load_valid}); end
    @(posedge clk) #1; clear_op();
    @(negedge clk);
    checks++;
    if ({load_valid, load_data} !== {1'b0, 32'hFFFF_FF80}) begin
      errors++; $display("FAIL lb_hold: lv=%b data=%h expected 0/ffffff80", load_valid, load_data);
    end
  endtask

  task automatic test_sh();
    @(posedge clk) #1; set_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sh_stall: got %b expected 1", stall); end
    @(posedge clk) #1; dmem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({dmem_req, dmem_we, dmem_be} !== 6'b11_1100) begin errors++; $display("FAIL sh_ctrl: req,we,be=%b expected 111100", {dmem_req, dmem_we, dmem_be}); end
    checks++;
    if ({dmem_addr, dmem_wdata} !== {32'h0000_0200, 32'hBEEF_BEEF}) begin
      errors++; $display("FAIL sh_data: addr=%h wdata=%h expected 00000200/beefbeef", dmem_addr, dmem_wdata);
    end
    @(posedge clk) #1; dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, dmem_req, load_valid} !== 3'b000) begin errors++; $display("FAIL sh_done: stall,req,lv=%b expected 000", {stall, dmem_req, load_valid}); end
    @(posedge clk) #1; clear_op();
  endtask

  task automatic test_fault();
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({addr_fault, stall, dmem_req} !== 3'b100) begin
        errors++; $display("FAIL lw_misaligned: fault,stall,req=%b expected 100", {addr_fault, stall, dmem_req});
      end
      @(posedge clk) #1;
    end
    set_op(1'b0, 1'b1, 3'b100, 32'h0000_0100, '0);
    @(negedge clk);
    checks++;
    if ({addr_fault, stall} !== 2'b10) begin errors++; $display("FAIL store_f3_100: fault,stall=%b expected 10", {addr_fault, stall}); end
    @(posedge clk) #1; set_op(1'b1, 1'b0, 3'b101, 32'h0000_0103, '0);
    @(negedge clk);
    checks++;
    if ({addr_fault, stall} !== 2'b10) begin errors++; $display("FAIL lhu_odd: fault,stall=%b expected 10", {addr_fault, stall}); end
    @(posedge clk) #1; clear_op();
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL fault_noreq: req=%b expected 0", dmem_req); end
  endtask

  task automatic test_lhu_wait();
    int unsigned sc = 0;
    @(posedge clk) #1; set_op(1'b1, 1'b0, 3'b101, 32'h0000_0102, '0);
    exp_q.push_back(32'h0000_ABCD);
    @(negedge clk); if (stall) sc++;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk) #1;
      if (c == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'hABCD_1234; end
      @(negedge clk); if (stall) sc++;
      checks++;
      if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== {1'b1, 1'b0, 4'b1100, 32'h0000_0100, 32'h0}) begin
        errors++; $display("FAIL lhu_stable: req=%b we=%b be=%b addr=%h wdata=%h expected 1/0/1100/00000100/0",
                           dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
      end
    end
    @(posedge clk) #1; dmem_ack = 1'b0; dmem_rdata = '0;
    @(negedge clk); if (stall) sc++;
    @(posedge clk) #1; clear_op();
    @(negedge clk); if (stall) sc++;
    checks++;
    if (sc != 4) begin errors++; $display("FAIL lhu_stall_cycles: got %0d expected 4", sc); end
  endtask

  task automatic test_async_reset();
    @(posedge clk) #1; set_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, '0);
    @(posedge clk) #1;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: req=%b expected 1", dmem_req); end
    @(posedge clk) #2; rst_n = 1'b0; clear_op();
    #1;
    checks++;
    if ({dmem_req, stall, dmem_we, dmem_be} !== 7'h0) begin
      errors++; $display("FAIL rst_async_ctrl: req,stall,we,be=%b expected 0", {dmem_req, stall, dmem_we, dmem_be});
    end
    checks++;
    if ({dmem_addr, load_data} !== 64'h0) begin
      errors++; $display("FAIL rst_async_data: addr=%h load_data=%h expected 0", dmem_addr, load_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk) #1; set_op(1'b1, 1'b0, 3'b100, 32'h0000_0001, '0);
    exp_q.push_back(32'h0000_009A);
    @(posedge clk) #1; dmem_ack = 1'b1; dmem_rdata = 32'h0000_9A00;
    @(negedge clk);
    checks++;
    if ({dmem_req, dmem_be, dmem_addr} !== {1'b1, 4'b0010, 32'h0}) begin
      errors++; $display("FAIL rst_restart: req=%b be=%b addr=%h expected 1/0010/0", dmem_req, dmem_be, dmem_addr);
    end
    @(posedge clk) #1; dmem_ack = 1'b0;
    @(posedge clk) #1; clear_op();
  endtask

  task automatic test_back_to_back();
    @(posedge clk) #1; set_op(1'b1, 1'b0, 3'b000, 32'h0000_0001, '0);
    exp_q.push_back(32'h0000_0056);
    @(posedge clk) #1; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge clk) #1; dmem_ack = 1'b0;
    @(posedge clk) #1; set_op(1'b1, 1'b0, 3'b001, 32'h0000_0002, '0);
    exp_q.push_back(32'hFFFF_8001);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL b2b_lh_start: stall=%b expected 1", stall); end
    @(posedge clk) #1; dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000;
    @(posedge clk) #1; dmem_ack = 1'b0;
    @(posedge clk) #1; set_op(1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'h1122_3344);
    @(posedge clk) #1; dmem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({dmem_be, dmem_addr, dmem_wdata} !== {4'b1111, 32'h0000_0004, 32'h1122_3344}) begin
      errors++; $display("FAIL b2b_sw: be=%b addr=%h wdata=%h expected 1111/00000004/11223344", dmem_be, dmem_addr, dmem_wdata);
    end
    @(posedge clk) #1; dmem_ack = 1'b0;
    @(posedge clk) #1; clear_op();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d loads outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    @(posedge clk) #1; set_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, '0); flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall, addr_fault} !== 2'b00) begin errors++; $display("FAIL flush_idle: stall,fault=%b expected 00", {stall, addr_fault}); end
    @(posedge clk) #1; flush = 1'b0; clear_op();
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0) begin errors++; $display("FAIL flush_idle_req: req=%b expected 0", dmem_req); end
    @(posedge clk) #1; set_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, '0);
    @(posedge clk) #1; flush = 1'b1;
    @(posedge clk) #1; flush = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({dmem_req, stall} !== 2'b11) begin errors++; $display("FAIL flush_req_held: req,stall=%b expected 11", {dmem_req, stall}); end
    @(posedge clk) #1; dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_valid, stall, dmem_req} !== 3'b000) begin
      errors++; $display("FAIL flush_req_done: lv,stall,req=%b expected 000", {load_valid, stall, dmem_req});
    end
    @(posedge clk) #1; clear_op();
  endtask

  task automatic test_timeout();
    int unsigned rc = 0;
    bit seen = 1'b0;
    @(posedge clk) #1; set_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, '0);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk) #1;
      @(negedge clk);
      if (dmem_req) rc++;
      if (bus_err) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL timeout_bus_err: bus_err=0 after 40 cycles expected pulse"); end
    checks++;
    if (rc != 16) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 16", rc); end
    checks++;
    if ({load_valid, dmem_req, load_data} !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL timeout_result: lv=%b req=%b data=%h expected 0/0/0", load_valid, dmem_req, load_data);
    end
    @(posedge clk) #1; clear_op();
    @(negedge clk);
    checks++;
    if ({bus_err, stall} !== 2'b00) begin errors++; $display("FAIL timeout_idle: bus_err,stall=%b expected 00", {bus_err, stall}); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_fault();
    test_lhu_wait();
    test_async_reset();
    test_back_to_back();
    test_flush();
    test_timeout();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d loads never returned expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
